// File: rtl/multdiv_controller_if.sv
// Signal bundle between the X stage and the multiply/divide sequencer.
// The master modport is the pipeline side and the slave modport is the controller.
interface multdiv_controller_if;
  logic [31:0] IR_X;
  logic [31:0] X_A_byp;
  logic [31:0] X_B_byp;
  logic        flush;
  logic        md_resultRDY;
  logic        md_exception;
  logic [31:0] md_result;

  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic        stall;
  logic        wb_valid;
  logic        wb_wren;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (
    output IR_X, X_A_byp, X_B_byp, flush, md_resultRDY, md_exception, md_result,
    input  ctrl_MULT, ctrl_DIV, md_opA, md_opB, stall, wb_valid, wb_wren, wb_rd, wb_data
  );

  modport slave (
    input  IR_X, X_A_byp, X_B_byp, flush, md_resultRDY, md_exception, md_result,
    output ctrl_MULT, ctrl_DIV, md_opA, md_opB, stall, wb_valid, wb_wren, wb_rd, wb_data
  );
endinterface

// File: rtl/multdiv_controller.sv
// X-stage sequencer for the multi-cycle multiply/divide unit: start pulse, operand
// latch, pipeline stall, timeout/exception handling and a one-cycle writeback packet.
module multdiv_controller #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  multdiv_controller_if.slave  md
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0]       OPC_ALU   = 5'b00000;
  localparam logic [4:0]       ALU_MUL   = 5'b00110;
  localparam logic [4:0]       ALU_DIV   = 5'b00111;
  localparam logic [4:0]       RSTATUS   = 5'd30;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

  state_t            state_reg,  state_next;
  logic [CNT_W-1:0]  cnt_reg,    cnt_next;
  logic [31:0]       op_a_reg,   op_a_next;
  logic [31:0]       op_b_reg,   op_b_next;
  logic [31:0]       result_reg, result_next;
  logic              exc_reg,    exc_next;
  logic              is_mul_reg, is_mul_next;
  logic [4:0]        rd_reg,     rd_next;

  logic        dec_mul;
  logic        dec_div;
  logic        is_md;
  logic        start_mul;
  logic        start_div;
  logic        stall_c;
  logic        wb_valid_c;
  logic        wb_wren_c;
  logic [4:0]  wb_rd_c;
  logic [31:0] wb_data_c;
  logic        unused_ir_bits;

  assign dec_mul = (md.IR_X[31:27] == OPC_ALU) && (md.IR_X[6:2] == ALU_MUL);
  assign dec_div = (md.IR_X[31:27] == OPC_ALU) && (md.IR_X[6:2] == ALU_DIV);
  assign is_md   = dec_mul | dec_div;

  // Register and shamt fields are irrelevant to the sequencer.
  assign unused_ir_bits = ^{md.IR_X[21:7], md.IR_X[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
      exc_reg    <= 1'b0;
      is_mul_reg <= 1'b0;
      rd_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_a_reg   <= op_a_next;
      op_b_reg   <= op_b_next;
      result_reg <= result_next;
      exc_reg    <= exc_next;
      is_mul_reg <= is_mul_next;
      rd_reg     <= rd_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_a_next   = op_a_reg;
    op_b_next   = op_b_reg;
    result_next = result_reg;
    exc_next    = exc_reg;
    is_mul_next = is_mul_reg;
    rd_next     = rd_reg;

    start_mul  = 1'b0;
    start_div  = 1'b0;
    stall_c    = 1'b0;
    wb_valid_c = 1'b0;
    wb_wren_c  = 1'b0;
    wb_rd_c    = '0;
    wb_data_c  = '0;

    unique case (state_reg)
      IDLE: begin
        if (is_md && !md.flush) begin
          start_mul   = dec_mul;
          start_div   = dec_div;
          stall_c     = 1'b1;
          op_a_next   = md.X_A_byp;
          op_b_next   = md.X_B_byp;
          is_mul_next = dec_mul;
          rd_next     = md.IR_X[26:22];
          cnt_next    = '0;
          state_next  = BUSY;
        end
      end

      BUSY: begin
        stall_c  = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        // A flush kills the instruction even if the unit finishes this very cycle.
        if (md.flush) begin
          state_next = IDLE;
        end else if (md.md_resultRDY) begin
          result_next = md.md_result;
          exc_next    = md.md_exception;
          state_next  = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          exc_next    = 1'b1;
          state_next  = DONE;
        end
      end

      DONE: begin
        wb_valid_c = 1'b1;
        if (exc_reg) begin
          wb_rd_c   = RSTATUS;
          wb_data_c = is_mul_reg ? 32'd1 : 32'd2;
          wb_wren_c = 1'b1;
        end else begin
          wb_rd_c   = rd_reg;
          wb_data_c = result_reg;
          wb_wren_c = (rd_reg != 5'd0);
        end
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Keep every control output quiet while reset is held.
    if (reset) begin
      start_mul  = 1'b0;
      start_div  = 1'b0;
      stall_c    = 1'b0;
      wb_valid_c = 1'b0;
      wb_wren_c  = 1'b0;
      wb_rd_c    = '0;
      wb_data_c  = '0;
    end
  end

  assign md.ctrl_MULT = start_mul;
  assign md.ctrl_DIV  = start_div;
  assign md.md_opA    = op_a_reg;
  assign md.md_opB    = op_b_reg;
  assign md.stall     = stall_c;
  assign md.wb_valid  = wb_valid_c;
  assign md.wb_wren   = wb_wren_c;
  assign md.wb_rd     = wb_rd_c;
  assign md.wb_data   = wb_data_c;

endmodule

// File: tb/tb_multdiv_controller.sv
// Self-checking bench for multdiv_controller: directed scenarios plus randomized
// operations, compared every cycle against a behavioural model of the sequencer.
module tb_multdiv_controller;

  localparam int MAX = 40;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset;

  multdiv_controller_if bus();

  multdiv_controller #(.MAX_CYCLES(MAX), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .md    (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 60)
        $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                 name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic mul);
    return {5'd0, rd, 5'd1, 5'd2, 5'd0, (mul ? 5'b00110 : 5'b00111), 2'b00};
  endfunction

  function automatic logic tb_is_md(input logic [31:0] ir);
    return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
  endfunction

  // ---------------- behavioural model ----------------
  logic        m_busy = 1'b0, m_done = 1'b0, m_mul = 1'b0, m_exc = 1'b0;
  int          m_n = 0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;

  always @(posedge clock) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_a <= '0; m_b <= '0;
      m_res <= '0; m_exc <= 1'b0; m_mul <= 1'b0; m_rd <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (bus.flush) m_busy <= 1'b0;
      else if (bus.md_resultRDY) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_res <= bus.md_result; m_exc <= bus.md_exception;
      end else if (m_n == MAX) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_exc <= 1'b1;
      end else m_n <= m_n + 1;
    end else if (tb_is_md(bus.IR_X) && !bus.flush) begin
      m_busy <= 1'b1; m_n <= 1;
      m_mul <= (bus.IR_X[6:2] == 5'd6);
      m_rd <= bus.IR_X[26:22];
      m_a <= bus.X_A_byp; m_b <= bus.X_B_byp;
    end
  end

  always @(negedge clock) begin
    logic e_start, e_stall, e_v, e_wren;
    logic [4:0] e_rd;
    logic [31:0] e_data;
    e_start = !reset && !m_busy && !m_done && tb_is_md(bus.IR_X) && !bus.flush;
    e_stall = !reset && (m_busy || e_start);
    e_v     = !reset && m_done;
    e_rd    = !e_v ? 5'd0 : (m_exc ? 5'd30 : m_rd);
    e_data  = !e_v ? 32'd0 : (m_exc ? (m_mul ? 32'd1 : 32'd2) : m_res);
    e_wren  = e_v && (m_exc || m_rd != 5'd0);
    chk("ctrl_MULT", 32'(bus.ctrl_MULT), 32'(e_start && bus.IR_X[6:2] == 5'd6));
    chk("ctrl_DIV",  32'(bus.ctrl_DIV),  32'(e_start && bus.IR_X[6:2] == 5'd7));
    chk("stall",     32'(bus.stall),     32'(e_stall));
    chk("wb_valid",  32'(bus.wb_valid),  32'(e_v));
    chk("wb_wren",   32'(bus.wb_wren),   32'(e_wren));
    chk("wb_rd",     32'(bus.wb_rd),     32'(e_rd));
    chk("wb_data",   bus.wb_data,        e_data);
    chk("md_opA",    bus.md_opA,         m_a);
    chk("md_opB",    bus.md_opB,         m_b);
  end

  // ---------------- per-operation driver ----------------
  int r_stall, r_mult, r_div, r_wb, r_first, r_done_c;
  logic [4:0] r_rd;
  logic [31:0] r_data;
  logic r_wren;

  // k = BUSY cycle carrying RDY (0 = never); flush_at = BUSY cycle with flush (0 = none)
  task automatic run_op(input string tag, input logic [31:0] ir, input logic [31:0] a,
                        input logic [31:0] b, input int k, input logic exc,
                        input logic [31:0] res, input int flush_at, input logic [31:0] a_late);
    logic mul, aborted, e_exc;
    int busy_len, stop_c;
    logic [4:0] e_rd;
    mul      = (ir[6:2] == 5'd6);
    busy_len = (k > 0) ? k : MAX;
    aborted  = (flush_at > 0) && (flush_at <= busy_len);
    stop_c   = ((k > flush_at) ? k : flush_at) + 2;
    r_stall = 0; r_mult = 0; r_div = 0; r_wb = 0; r_first = -1; r_done_c = -1;
    r_rd = '0; r_data = '0; r_wren = 1'b0;
    for (int c = 0; c < MAX + 8; c++) begin
      if (c == 0) begin bus.IR_X = ir; bus.X_A_byp = a; bus.X_B_byp = b; end
      if (c == 2) bus.X_A_byp = a_late;
      bus.md_resultRDY = (c > 0 && c == k);
      bus.md_exception = (c > 0 && c == k) ? exc : 1'b0;
      bus.md_result    = (c > 0 && c == k) ? res : $urandom;
      bus.flush        = (c > 0 && c == flush_at);
      if (aborted && c == flush_at + 1) bus.IR_X = NOP;
      @(negedge clock);
      r_stall += int'(bus.stall);
      r_mult  += int'(bus.ctrl_MULT);
      r_div   += int'(bus.ctrl_DIV);
      if ((bus.ctrl_MULT || bus.ctrl_DIV) && r_first < 0) r_first = c;
      if (bus.wb_valid) begin
        r_wb++; r_done_c = c; r_rd = bus.wb_rd; r_data = bus.wb_data; r_wren = bus.wb_wren;
      end
      @(posedge clock); #1;
      if (r_wb > 0) break;
      if (aborted && c >= stop_c) break;
    end
    bus.md_resultRDY = 1'b0; bus.md_exception = 1'b0; bus.flush = 1'b0;
    chk({tag, " stall cycles"}, r_stall, aborted ? flush_at + 1 : busy_len + 1);
    chk({tag, " mult pulses"}, r_mult, mul ? 1 : 0);
    chk({tag, " div pulses"}, r_div, mul ? 0 : 1);
    chk({tag, " start cycle"}, r_first, 0);
    chk({tag, " wb count"}, r_wb, aborted ? 0 : 1);
    if (!aborted) begin
      e_exc = (k == 0) || exc;
      e_rd  = e_exc ? 5'd30 : ir[26:22];
      chk({tag, " done cycle"}, r_done_c, busy_len + 1);
      chk({tag, " wb_rd"}, r_rd, e_rd);
      chk({tag, " wb_data"}, r_data, e_exc ? (mul ? 32'd1 : 32'd2) : res);
      chk({tag, " wb_wren"}, r_wren, e_exc || e_rd != 5'd0);
    end
  endtask

  task automatic idle_cycles(input int n);
    logic [31:0] not_md [3];
    not_md[0] = NOP;
    not_md[1] = {5'b00101, 5'd3, 5'd1, 5'd2, 5'd0, 5'b00110, 2'b00};
    not_md[2] = {5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'b00101, 2'b00};
    for (int i = 0; i < n; i++) begin
      bus.IR_X = not_md[$urandom_range(0, 2)];
      bus.md_resultRDY = $urandom_range(0, 1);
      bus.md_exception = $urandom_range(0, 1);
      bus.md_result = $urandom;
      bus.flush = $urandom_range(0, 1);
      @(posedge clock); #1;
    end
    bus.IR_X = NOP; bus.md_resultRDY = 1'b0; bus.md_exception = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.IR_X = NOP; bus.X_A_byp = '0; bus.X_B_byp = '0; bus.flush = 1'b0;
    bus.md_resultRDY = 1'b0; bus.md_exception = 1'b0; bus.md_result = '0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("reset stall", 32'(bus.stall), 0);
    chk("reset wb_valid", 32'(bus.wb_valid), 0);
    chk("reset md_opA", bus.md_opA, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // mul r3 = 7*6, RDY on the 4th BUSY cycle
    run_op("t1", mk(5'd3, 1'b1), 32'd7, 32'd6, 4, 1'b0, 32'd42, 0, 32'd7);
    chk("t1 stall literal", r_stall, 5);
    chk("t1 wb_data literal", r_data, 42);
    chk("t1 wb_rd literal", r_rd, 3);
    bus.IR_X = NOP;
    idle_cycles(1);

    // div r5 with unit exception
    run_op("t2", mk(5'd5, 1'b0), 32'd9, 32'd0, 3, 1'b1, 32'd1234, 0, 32'd9);
    chk("t2 wb_rd literal", r_rd, 30);
    chk("t2 wb_data literal", r_data, 2);
    bus.IR_X = NOP;
    idle_cycles(2);

    // mul that never completes: watchdog timeout
    run_op("t3", mk(5'd9, 1'b1), 32'd1, 32'd2, 0, 1'b0, 32'd0, 0, 32'd1);
    chk("t3 stall literal", r_stall, 41);
    chk("t3 wb_data literal", r_data, 1);
    bus.IR_X = NOP;
    idle_cycles(1);

    // flush in BUSY cycle 2, RDY in cycle 3 must be ignored
    run_op("t4", mk(5'd4, 1'b1), 32'd3, 32'd3, 3, 1'b0, 32'd9, 2, 32'd3);
    chk("t4 wb literal", r_wb, 0);
    chk("t4 stall literal", r_stall, 3);

    // Rd = 0, then back-to-back div
    run_op("t5", mk(5'd0, 1'b1), 32'd9, 32'd11, 2, 1'b0, 32'd99, 0, 32'd9);
    chk("t5 wren literal", 32'(r_wren), 0);
    run_op("t5b", mk(5'd6, 1'b0), 32'd100, 32'd7, 5, 1'b0, 32'd14, 0, 32'd100);
    chk("t5b start literal", r_first, 0);
    bus.IR_X = NOP;
    idle_cycles(1);

    // flush on the start cycle suppresses the start
    bus.IR_X = mk(5'd4, 1'b0); bus.flush = 1'b1;
    @(negedge clock);
    chk("flush-start stall", 32'(bus.stall), 0);
    chk("flush-start div", 32'(bus.ctrl_DIV), 0);
    @(posedge clock); #1;
    bus.IR_X = NOP; bus.flush = 1'b0;
    idle_cycles(1);

    // bypass change during BUSY, then reset mid-BUSY
    bus.IR_X = mk(5'd7, 1'b1); bus.X_A_byp = 32'd11; bus.X_B_byp = 32'd3;
    @(posedge clock); #1;
    bus.X_A_byp = 32'd99;
    @(negedge clock);
    chk("t6 opA held", bus.md_opA, 11);
    chk("t6 busy stall", 32'(bus.stall), 1);
    @(posedge clock); #1;
    reset = 1'b1; bus.IR_X = NOP;
    @(negedge clock);
    chk("t6 reset stall", 32'(bus.stall), 0);
    @(posedge clock); #1;
    reset = 1'b0; bus.md_resultRDY = 1'b1; bus.md_result = 32'd5;
    @(negedge clock);
    chk("t6 post-reset opA", bus.md_opA, 0);
    chk("t6 post-reset wb_valid", 32'(bus.wb_valid), 0);
    @(posedge clock); #1;
    bus.md_resultRDY = 1'b0;
    idle_cycles(1);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ir, a, b;
      int k, fa;
      ir = mk(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      a = $urandom; b = $urandom;
      k = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 6);
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (k > 0) ? k + 1 : MAX) : 0;
      run_op($sformatf("rnd%0d", n), ir, a, b, k, 1'($urandom_range(0, 3) == 0),
             $urandom, fa, $urandom);
      if ($urandom_range(0, 2) != 0) begin
        bus.IR_X = NOP;
        idle_cycles($urandom_range(0, 3));
      end
    end
    bus.IR_X = NOP;
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
